qformat_dot_product: RTL

- Consumes streams of signed Q-format operand pairs from the signed_qformat stage, where each operand is NUM_FIXED_BITS.NUM_FRACTIONAL_BITS.
- Computes a rounded, saturated dot product over one vector and returns it in the same Q format.
- Sits directly downstream of the Q-format value producers and feeds the neuron activation stage.
- Uses a valid/ready handshake on both input and output, a 2-stage multiply/accumulate pipeline and a small control FSM.

---
 rtl/qformat_dot_product.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/qformat_dot_product.sv
// qformat_dot_product
// -------------------
// Purpose: accumulates a stream of signed Q-format operand pairs into a dot
// product and returns the rounded, saturated result in the same Q format.
// A two-stage pipeline registers the full-precision product (stage 1) and
// folds it into a wide accumulator (stage 2). A three-state control FSM
// (ACCUM -> FLUSH -> RESULT) sequences vector termination and the result
// handshake.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   in_valid       operand pair valid
//   in_ready       block accepts a pair this cycle (only in ACCUM)
//   in_a, in_b     signed Q(NUM_FIXED_BITS.NUM_FRACTIONAL_BITS) operands
//   in_last        final pair of the vector
//   out_valid      result valid (only in RESULT)
//   out_ready      consumer accepts the result
//   out_value      signed Q-format dot product
//   out_saturated  result was clipped; qualified by out_valid

module qformat_dot_product #(
  parameter int NUM_FIXED_BITS      = 8,
  parameter int NUM_FRACTIONAL_BITS = 8,
  parameter int MAX_BEATS           = 16
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic signed [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0] in_a,
  input  logic signed [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0] in_b,
  input  logic                                                in_last,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic signed [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0] out_value,
  output logic                                                out_saturated
);

  localparam int T     = NUM_FIXED_BITS + NUM_FRACTIONAL_BITS;
  localparam int PW    = 2 * T;
  // Enough headroom that MAX_BEATS worst-case products can never wrap.
  localparam int ACC_W = PW + $clog2(MAX_BEATS) + 1;
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (NUM_FRACTIONAL_BITS - 1);
  localparam logic signed [ACC_W-1:0] QMAX = {{(ACC_W-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] QMIN = {{(ACC_W-T+1){1'b1}}, {(T-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FLUSH  = 2'd1,
    RESULT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]        beatCnt_q;
  logic signed [PW-1:0]    prod_q;
  logic                    pValid_q;
  logic                    pFirst_q;
  logic                    pLast_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [T-1:0]            outValue_q;
  logic                    outSat_q;

  logic                    accept;
  logic                    lastBeatD;
  logic signed [PW-1:0]    prodFull;
  logic signed [ACC_W-1:0] prodExt;
  logic signed [ACC_W-1:0] accNext;
  logic signed [ACC_W-1:0] roundSum;
  logic signed [ACC_W-1:0] qShift;
  logic [T-1:0]            resultValue;
  logic                    resultSat;

  assign in_ready      = (state_q == ACCUM);
  assign out_valid     = (state_q == RESULT);
  assign out_value     = outValue_q;
  assign out_saturated = outSat_q;

  assign accept = in_valid && in_ready;

  // A beat ends the vector either because the producer says so or because
  // the beat counter has hit the cap; both together still give one ending.
  assign lastBeatD = in_last || (beatCnt_q == LAST_BEAT);

  // Sign-extend both operands to full product width so the multiply is
  // exact without relying on context-width rules.
  assign prodFull = $signed({{T{in_a[T-1]}}, in_a}) * $signed({{T{in_b[T-1]}}, in_b});
  assign prodExt  = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

  // Stage-2 accumulate plus round-half-up and clip. Adding half an LSB and
  // then arithmetic-shifting rounds ties toward +infinity. Only the final
  // value is clipped; the accumulator itself is wide enough never to wrap.
  always_comb begin
    accNext     = (pFirst_q ? '0 : acc_q) + prodExt;
    roundSum    = accNext + ROUND_HALF;
    qShift      = roundSum >>> NUM_FRACTIONAL_BITS;
    resultValue = qShift[T-1:0];
    resultSat   = 1'b0;
    if (qShift > QMAX) begin
      resultValue = QMAX[T-1:0];
      resultSat   = 1'b1;
    end else if (qShift < QMIN) begin
      resultValue = QMIN[T-1:0];
      resultSat   = 1'b1;
    end
  end

  // Control FSM next-state logic. FLUSH is a fixed single cycle that lets
  // stage 2 swallow the last product before the result is presented.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && lastBeatD) state_d = FLUSH;
      FLUSH:   state_d = RESULT;
      RESULT:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State register; reset abandons any partial vector or pending result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: stage 1 captures the product and its position flags on every
  // accepted pair, stage 2 folds the previous product into the accumulator
  // and, on the vector's last product, latches the rounded result. The
  // result registers are only written on that last product, so they stay
  // stable for as long as the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      beatCnt_q  <= '0;
      prod_q     <= '0;
      pValid_q   <= 1'b0;
      pFirst_q   <= 1'b0;
      pLast_q    <= 1'b0;
      acc_q      <= '0;
      outValue_q <= '0;
      outSat_q   <= 1'b0;
    end else begin
      pValid_q <= accept;
      if (accept) begin
        prod_q    <= prodFull;
        pFirst_q  <= (beatCnt_q == '0);
        pLast_q   <= lastBeatD;
        beatCnt_q <= lastBeatD ? '0 : beatCnt_q + CNT_W'(1);
      end
      if (pValid_q) begin
        acc_q <= accNext;
        if (pLast_q) begin
          outValue_q <= resultValue;
          outSat_q   <= resultSat;
        end
      end
    end
  end

endmodule
